// File: rtl/fifo_0_pkg.sv
// Shared constants for the FIFO read-side sample packer.
package fifo_0_pkg;
  localparam int DATA_WIDTH_DEF = 10;
  localparam int PACK_NUM_DEF   = 3;
  localparam int FRAME_LEN_DEF  = 256;
  // pkt_keep width (lane count 1..PACK_NUM)
  localparam int KEEP_W         = 3;
  // lane index width, holds 0..PACK_NUM-1
  localparam int LANE_W         = 3;
  // lane fill count width, holds 0..PACK_NUM
  localparam int FILL_W         = 4;
endpackage

// File: rtl/fifo_0_pack_lane.sv
// Lane register plus zero-pad mux. The padded view already includes the
// sample being written this cycle, so the top can load a word on the same
// edge that delivers its final (or flush-coincident) sample.
module fifo_0_pack_lane
  import fifo_0_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_NUM   = PACK_NUM_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [LANE_W-1:0]              wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [FILL_W-1:0]              fill_cnt,
  output logic [DATA_WIDTH*PACK_NUM-1:0] padded
);

  logic [DATA_WIDTH-1:0] lanes [PACK_NUM];

  // Store each incoming sample into its lane slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PACK_NUM; i++) lanes[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < PACK_NUM; i++) begin
        if (wr_idx == LANE_W'(i)) lanes[i] <= wr_data;
      end
    end
  end

  // Present lanes below fill_cnt (with the bypassed write), zero the rest.
  always_comb begin
    padded = '0;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (FILL_W'(i) < fill_cnt) begin
        padded[i*DATA_WIDTH +: DATA_WIDTH] =
          (wr_en && (wr_idx == LANE_W'(i))) ? wr_data : lanes[i];
      end
    end
  end

endmodule

// File: rtl/fifo_0_rd_packer.sv
// Packs PACK_NUM FIFO samples into one output word (first sample in LSBs),
// frames words with pkt_last every FRAME_LEN words, and supports an early
// frame close through a single-cycle flush request.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (fifo_rd_vld/fifo_rd_en on input, pkt_vld/pkt_rdy on output);
// pkt_data/pkt_keep/pkt_last hold steady while pkt_vld=1 and pkt_rdy=0.
module fifo_0_rd_packer
  import fifo_0_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_NUM   = PACK_NUM_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  input  logic                           fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
  output logic                           fifo_rd_en,
  input  logic                           flush,
  output logic [DATA_WIDTH*PACK_NUM-1:0] pkt_data,
  output logic [KEEP_W-1:0]              pkt_keep,
  output logic                           pkt_vld,
  input  logic                           pkt_rdy,
  output logic                           pkt_last,
  output logic [15:0]                    frame_cnt
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_NUM - 1);
  localparam logic [FILL_W-1:0] FULL_KEEP = FILL_W'(PACK_NUM);
  localparam logic [15:0]       LAST_WORD = 16'(FRAME_LEN - 1);

  logic [LANE_W-1:0]              lane_cnt;
  logic [15:0]                    word_cnt;
  logic                           flush_pend;
  logic                           pend_last;

  logic                           in_fire;
  logic                           out_fire;
  logic                           out_free;
  logic                           complete;
  logic [FILL_W-1:0]              eff_cnt;

  logic                           load;
  logic                           load_last;
  logic [FILL_W-1:0]              load_keep;
  logic                           set_pend;
  logic                           mark_held;
  logic                           set_pend_last;
  logic [DATA_WIDTH*PACK_NUM-1:0] padded;

  assign out_fire   = pkt_vld && pkt_rdy;
  assign out_free   = !pkt_vld || pkt_rdy;
  // Lanes below the last can always take a sample; the last lane needs a
  // free output register. A pending flush freezes the input side.
  assign fifo_rd_en = !rd_rst && !flush_pend && ((lane_cnt < LAST_LANE) || out_free);
  assign in_fire    = fifo_rd_vld && fifo_rd_en;
  assign complete   = in_fire && (lane_cnt == LAST_LANE);
  // Lanes occupied once this cycle's sample (if any) is counted.
  assign eff_cnt    = {1'b0, lane_cnt} + {{(FILL_W-1){1'b0}}, in_fire};

  fifo_0_pack_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_NUM   (PACK_NUM)
  ) u_lane (
    .clk      (rd_clk),
    .rst      (rd_rst),
    .wr_en    (in_fire),
    .wr_idx   (lane_cnt),
    .wr_data  (fifo_rd_data),
    .fill_cnt (load_keep),
    .padded   (padded)
  );

  // Decide this cycle's load and flush actions.
  always_comb begin
    load          = 1'b0;
    load_last     = 1'b0;
    load_keep     = '0;
    set_pend      = 1'b0;
    mark_held     = 1'b0;
    set_pend_last = 1'b0;
    if (flush_pend) begin
      // Input is blocked, so lane_cnt is the final partial size.
      if (out_free) begin
        load      = 1'b1;
        load_last = 1'b1;
        load_keep = {1'b0, lane_cnt};
      end
    end else if (flush && (eff_cnt != '0)) begin
      // Close the frame with whatever lanes exist, including a coincident sample.
      if (complete || out_free) begin
        load      = 1'b1;
        load_last = 1'b1;
        load_keep = eff_cnt;
      end else begin
        set_pend  = 1'b1;
      end
    end else begin
      if (complete) begin
        load      = 1'b1;
        load_last = (word_cnt == LAST_WORD) || pend_last;
        load_keep = FULL_KEEP;
      end
      // No lanes held: end the frame on the held word, or on the next one.
      if (flush && (word_cnt != '0)) begin
        if (pkt_vld && !pkt_rdy) mark_held     = 1'b1;
        else                     set_pend_last = 1'b1;
      end
    end
  end

  // Output register, counters and flush state.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pkt_vld    <= 1'b0;
      pkt_last   <= 1'b0;
      pkt_data   <= '0;
      pkt_keep   <= '0;
      lane_cnt   <= '0;
      word_cnt   <= '0;
      frame_cnt  <= '0;
      flush_pend <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      if (load) begin
        pkt_vld  <= 1'b1;
        pkt_data <= padded;
        pkt_keep <= load_keep[KEEP_W-1:0];
        pkt_last <= load_last;
      end else begin
        if (out_fire)  pkt_vld  <= 1'b0;
        if (mark_held) pkt_last <= 1'b1;
      end

      if (load)         lane_cnt <= '0;
      else if (in_fire) lane_cnt <= lane_cnt + 1'b1;

      if (load)          word_cnt <= load_last ? 16'd0 : word_cnt + 16'd1;
      else if (mark_held || set_pend_last) word_cnt <= 16'd0;

      if (load)          flush_pend <= 1'b0;
      else if (set_pend) flush_pend <= 1'b1;

      if (load)               pend_last <= 1'b0;
      else if (set_pend_last) pend_last <= 1'b1;

      if (out_fire && pkt_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_0_rd_packer.sv
// Directed bench for fifo_0_rd_packer with a short frame (FRAME_LEN=4).
module tb_fifo_0_rd_packer;

  localparam int DW = 10;
  localparam int PN = 3;
  localparam int FL = 4;
  localparam int W  = 1 + 3 + DW*PN;

  logic           rd_clk = 1'b0;
  logic           rd_rst = 1'b1;
  logic           fifo_rd_vld = 1'b0;
  logic [DW-1:0]  fifo_rd_data = '0;
  logic           fifo_rd_en;
  logic           flush = 1'b0;
  logic [DW*PN-1:0] pkt_data;
  logic [2:0]     pkt_keep;
  logic           pkt_vld;
  logic           pkt_rdy = 1'b1;
  logic           pkt_last;
  logic [15:0]    frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  logic [W-1:0] exp_q[$];

  fifo_0_rd_packer #(.DATA_WIDTH(DW), .PACK_NUM(PN), .FRAME_LEN(FL)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .pkt_data     (pkt_data),
    .pkt_keep     (pkt_keep),
    .pkt_vld      (pkt_vld),
    .pkt_rdy      (pkt_rdy),
    .pkt_last     (pkt_last),
    .frame_cnt    (frame_cnt)
  );

  // clock / reset
  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) cyc_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] wrd(input logic l, input logic [2:0] k,
                                       input logic [DW-1:0] d2, input logic [DW-1:0] d1,
                                       input logic [DW-1:0] d0);
    return {l, k, d2, d1, d0};
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  // Present a sample and return just after the edge that accepts it;
  // fifo_rd_vld stays high so consecutive pushes run back-to-back.
  task automatic push(input logic [DW-1:0] d);
    int k;
    k = 0;
    fifo_rd_vld  = 1'b1;
    fifo_rd_data = d;
    while (!fifo_rd_en && k < 50) begin
      @(posedge rd_clk); #1;
      k++;
    end
    if (k >= 50) check("push_timeout", k, 0);
    @(posedge rd_clk); #1;
  endtask

  task automatic idle();
    fifo_rd_vld = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge rd_clk); #1;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    cyc(2);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_vld", pkt_vld, 0);
    rd_rst = 1'b0;
    cyc(1);
  endtask

  task automatic drain(input string tag);
    idle();
    cyc(4);
    check(tag, exp_q.size(), 0);
  endtask

  // scoreboard: every accepted word must match the head of exp_q
  always @(negedge rd_clk) begin
    if (!rd_rst && pkt_vld && pkt_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {pkt_last, pkt_keep, pkt_data}, 0);
      end else begin
        check("word", {pkt_last, pkt_keep, pkt_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int t0;
    // reset state
    cyc(1);
    check("reset_vld", pkt_vld, 0);
    check("reset_last", pkt_last, 0);
    check("reset_data", pkt_data, 0);
    check("reset_keep", pkt_keep, 0);
    check("reset_frame", frame_cnt, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    rd_rst = 1'b0;
    cyc(1);
    check("rd_en_after_reset", fifo_rd_en, 1);

    // two full words back-to-back, one cycle latency
    exp_q.push_back(wrd(0, 3, 10'h003, 10'h002, 10'h001));
    exp_q.push_back(wrd(0, 3, 10'h006, 10'h005, 10'h004));
    push(10'h001);
    push(10'h002);
    check("lat_before", pkt_vld, 0);
    push(10'h003);
    check("lat_vld", pkt_vld, 1);
    check("lat_data", pkt_data, {10'h003, 10'h002, 10'h001});
    push(10'h004); push(10'h005); push(10'h006);
    check("lat_data2", pkt_data, {10'h006, 10'h005, 10'h004});
    drain("basic_drain");

    // partial word closed by flush
    do_reset();
    exp_q.push_back(wrd(1, 2, 10'h000, 10'h0BB, 10'h0AA));
    push(10'h0AA); push(10'h0BB); idle();
    cyc(1);
    check("partial_rd_en", fifo_rd_en, 1);
    pulse_flush();
    check("partial_vld", pkt_vld, 1);
    check("partial_keep", pkt_keep, 2);
    check("partial_last", pkt_last, 1);
    drain("partial_drain");
    check("partial_frame", frame_cnt, 1);

    // 12 samples, FRAME_LEN=4, no stalls
    do_reset();
    for (int j = 0; j < 4; j++)
      exp_q.push_back(wrd(j == 3, 3, 10'(16'h100 + 3*j + 2), 10'(16'h100 + 3*j + 1),
                          10'(16'h100 + 3*j)));
    t0 = cyc_cnt;
    for (int i = 0; i < 12; i++) begin
      push(10'(16'h100 + i));
      if (i == 8) check("frame_mid", frame_cnt, 0);
    end
    check("stream_cycles", cyc_cnt - t0, 12);
    drain("frame_drain");
    check("frame_done", frame_cnt, 1);

    // backpressure: held word stable, input stalls, nothing lost
    do_reset();
    pkt_rdy = 1'b0;
    exp_q.push_back(wrd(0, 3, 10'h003, 10'h002, 10'h001));
    exp_q.push_back(wrd(0, 3, 10'h006, 10'h005, 10'h004));
    push(10'h001); push(10'h002); push(10'h003);
    push(10'h004); push(10'h005); idle();
    check("bp_rd_en", fifo_rd_en, 0);
    for (int i = 0; i < 10; i++) begin
      check("bp_data", pkt_data, {10'h003, 10'h002, 10'h001});
      cyc(1);
    end
    check("bp_vld", pkt_vld, 1);
    pkt_rdy = 1'b1;
    push(10'h006);
    drain("bp_drain");

    // reset mid-word discards the partial
    do_reset();
    push(10'h077); idle();
    rd_rst = 1'b1;
    cyc(2);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    rd_rst = 1'b0;
    cyc(3);
    check("mid_rst_vld", pkt_vld, 0);
    exp_q.push_back(wrd(0, 3, 10'h033, 10'h022, 10'h011));
    push(10'h011); push(10'h022); push(10'h033);
    drain("mid_rst_drain");

    // flush coincident with the completing sample
    do_reset();
    exp_q.push_back(wrd(1, 3, 10'h033, 10'h022, 10'h011));
    push(10'h011); push(10'h022);
    flush = 1'b1;
    push(10'h033);
    flush = 1'b0;
    check("coin_keep", pkt_keep, 3);
    check("coin_last", pkt_last, 1);
    drain("coin_drain");
    check("coin_vld", pkt_vld, 0);
    check("coin_frame", frame_cnt, 1);

    // flush with no lanes: marks the held word
    do_reset();
    pkt_rdy = 1'b0;
    exp_q.push_back(wrd(1, 3, 10'h003, 10'h002, 10'h001));
    push(10'h001); push(10'h002); push(10'h003); idle();
    check("held_last_before", pkt_last, 0);
    pulse_flush();
    check("held_last", pkt_last, 1);
    pkt_rdy = 1'b1;
    drain("held_drain");
    check("held_frame", frame_cnt, 1);

    // flush with no lanes after acceptance: next word carries last
    do_reset();
    exp_q.push_back(wrd(0, 3, 10'h003, 10'h002, 10'h001));
    exp_q.push_back(wrd(1, 3, 10'h006, 10'h005, 10'h004));
    push(10'h001); push(10'h002); push(10'h003); idle();
    cyc(2);
    pulse_flush();
    check("pend_frame0", frame_cnt, 0);
    push(10'h004); push(10'h005); push(10'h006);
    drain("pend_drain");
    check("pend_frame", frame_cnt, 1);
    // idle flush has no effect
    pulse_flush();
    cyc(3);
    check("noop_vld", pkt_vld, 0);
    check("noop_frame", frame_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
